eth_rx_axi_writer: RTL and testbench



---
 rtl/eth_dma_pkg.sv | 34 +++
 rtl/eth_word_fifo.sv | 56 +++++
 rtl/eth_rx_axi_writer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_eth_rx_axi_writer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_dma_pkg.sv
// Shared constants and state types for the Ethernet receive DMA writer.
// AXI field encodings, status bit positions and the frame/writer FSM encodings.
package eth_dma_pkg;

  localparam logic [1:0] AXI_ID         = 2'b00;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int STAT_RX_ERR    = 0;
  localparam int STAT_OVERFLOW  = 1;
  localparam int STAT_BRESP_ERR = 2;

  typedef enum logic [2:0] {
    F_IDLE  = 3'd0,
    F_ARMED = 3'd1,
    F_RECV  = 3'd2,
    F_FLUSH = 3'd3,
    F_DONE  = 3'd4
  } frame_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

  // Byte span of a burst given its AXI len field (beats-1).
  function automatic logic [31:0] burst_bytes(input logic [7:0] len);
    return ({24'd0, len} + 32'd1) << 2;
  endfunction

endpackage

// File: rtl/eth_word_fifo.sv
// Synchronous word FIFO carrying packed data plus byte strobes, with occupancy count.
module eth_word_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign data_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/eth_rx_axi_writer.sv
// Ethernet receive DMA: packs MAC bytes into little-endian words and writes the
// frame to memory through AXI4 write bursts, reporting length and status when done.
module eth_rx_axi_writer
  import eth_dma_pkg::*;
#(
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm_i,
  input  logic [31:0]      base_addr_i,
  input  logic [LEN_W-1:0] buf_len_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  input  logic             rx_last_i,
  input  logic             rx_err_i,
  output logic             rx_ready_o,
  output logic             aw_valid_o,
  input  logic             aw_ready_i,
  output logic [31:0]      aw_addr_o,
  output logic [7:0]       aw_len_o,
  output logic             w_valid_o,
  input  logic             w_ready_i,
  output logic [31:0]      w_data_o,
  output logic [3:0]       w_strb_o,
  output logic             w_last_o,
  input  logic             b_valid_i,
  output logic             b_ready_o,
  input  logic [1:0]       b_resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] frame_len_o,
  output logic [2:0]       status_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_LEN);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  frame_state_e fstate_q, fstate_d;
  wr_state_e    wstate_q, wstate_d;

  logic [LEN_W-1:0] buf_len_q, byte_cnt_q, byte_cnt_d;
  logic [31:0]      pack_data_q, pack_data_d;
  logic [3:0]       pack_strb_q, pack_strb_d;
  logic             push_q, push_d;
  logic [31:0]      push_data_q, push_data_d;
  logic [3:0]       push_strb_q, push_strb_d;
  logic             overflow_q, overflow_d;
  logic             rx_err_q, rx_err_d;
  logic             bresp_err_q, bresp_err_d;
  logic [31:0]      addr_q, addr_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       beat_q, beat_d;
  logic             rx_ready_q, rx_ready_d;
  logic             done_q, busy_q;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic [2:0]       status_q, status_d;

  logic             accept_s, arm_accept_s, w_hs_s, full_go_s, flush_go_s;
  logic [1:0]       lane_s;
  logic             in_buf_s;
  logic [31:0]      word_s;
  logic [3:0]       strb_s;
  logic [OCC_W-1:0] occ_s;
  logic [35:0]      fifo_rdata_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic             fifo_full_s, fifo_empty_s;

  assign accept_s     = rx_valid_i && rx_ready_q;
  assign arm_accept_s = (fstate_q == F_IDLE) && arm_i;
  assign w_hs_s       = (wstate_q == W_DATA) && w_ready_i;
  assign lane_s       = byte_cnt_q[1:0];
  assign in_buf_s     = (byte_cnt_q < buf_len_q);
  assign full_go_s    = (fifo_count_s >= BURST_C);
  assign flush_go_s   = (fstate_q == F_FLUSH) && !push_q && !fifo_empty_s;

  eth_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(36)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .data_i  ({push_strb_q, push_data_q}),
    .pop_i   (w_hs_s),
    .data_o  (fifo_rdata_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fstate_q    <= F_IDLE;
      wstate_q    <= W_IDLE;
      buf_len_q   <= {LEN_W{1'b0}};
      byte_cnt_q  <= {LEN_W{1'b0}};
      pack_data_q <= 32'd0;
      pack_strb_q <= 4'd0;
      push_q      <= 1'b0;
      push_data_q <= 32'd0;
      push_strb_q <= 4'd0;
      overflow_q  <= 1'b0;
      rx_err_q    <= 1'b0;
      bresp_err_q <= 1'b0;
      addr_q      <= 32'd0;
      len_q       <= 8'd0;
      beat_q      <= 8'd0;
      rx_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_len_q <= {LEN_W{1'b0}};
      status_q    <= 3'd0;
    end else begin
      fstate_q    <= fstate_d;
      wstate_q    <= wstate_d;
      buf_len_q   <= arm_accept_s ? buf_len_i : buf_len_q;
      byte_cnt_q  <= byte_cnt_d;
      pack_data_q <= pack_data_d;
      pack_strb_q <= pack_strb_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      push_strb_q <= push_strb_d;
      overflow_q  <= overflow_d;
      rx_err_q    <= rx_err_d;
      bresp_err_q <= bresp_err_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      rx_ready_q  <= rx_ready_d;
      done_q      <= (fstate_d == F_DONE);
      busy_q      <= (fstate_d == F_ARMED) || (fstate_d == F_RECV) || (fstate_d == F_FLUSH);
      frame_len_q <= frame_len_d;
      status_q    <= status_d;
    end
  end

  // The frame may only finish once every word has left and the last response is in.
  always_comb begin
    fstate_d = fstate_q;
    case (fstate_q)
      F_IDLE:  fstate_d = arm_i ? F_ARMED : F_IDLE;
      F_ARMED: begin
        if (accept_s) fstate_d = rx_last_i ? F_FLUSH : F_RECV;
        else          fstate_d = F_ARMED;
      end
      F_RECV:  fstate_d = (accept_s && rx_last_i) ? F_FLUSH : F_RECV;
      F_FLUSH: begin
        if (fifo_empty_s && !push_q &&
            ((wstate_q == W_IDLE) || ((wstate_q == W_RESP) && b_valid_i)))
          fstate_d = F_DONE;
        else
          fstate_d = F_FLUSH;
      end
      F_DONE:  fstate_d = F_IDLE;
      default: fstate_d = F_IDLE;
    endcase
  end

  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    pack_data_d = pack_data_q;
    pack_strb_d = pack_strb_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    push_strb_d = push_strb_q;
    overflow_d  = overflow_q;
    rx_err_d    = rx_err_q;
    word_s      = pack_data_q;
    strb_s      = pack_strb_q;
    if (arm_accept_s) begin
      byte_cnt_d  = {LEN_W{1'b0}};
      pack_data_d = 32'd0;
      pack_strb_d = 4'd0;
      overflow_d  = 1'b0;
      rx_err_d    = 1'b0;
    end else if (accept_s) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
      // Bytes past the buffer are counted but never reach a lane.
      if (in_buf_s) begin
        word_s[{lane_s, 3'b000} +: 8] = rx_data_i;
        strb_s[lane_s]                = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
      rx_err_d = rx_last_i ? (rx_err_q | rx_err_i) : rx_err_q;
      if ((in_buf_s && (lane_s == 2'd3)) || (rx_last_i && (strb_s != 4'd0))) begin
        push_d      = 1'b1;
        push_data_d = word_s;
        push_strb_d = strb_s;
        pack_data_d = 32'd0;
        pack_strb_d = 4'd0;
      end else begin
        pack_data_d = word_s;
        pack_strb_d = strb_s;
      end
    end else begin
      byte_cnt_d = byte_cnt_q;
    end
  end

  // Writer: a partial burst is only issued in FLUSH once the final word has landed.
  always_comb begin
    wstate_d    = wstate_q;
    len_d       = len_q;
    beat_d      = beat_q;
    addr_d      = addr_q;
    bresp_err_d = bresp_err_q;
    case (wstate_q)
      W_IDLE: begin
        if (full_go_s || flush_go_s) begin
          wstate_d = W_AW;
          len_d    = full_go_s ? 8'(BURST_LEN - 1) : 8'(fifo_count_s - 1'b1);
          beat_d   = 8'd0;
        end else begin
          wstate_d = W_IDLE;
        end
      end
      W_AW:   wstate_d = aw_ready_i ? W_DATA : W_AW;
      W_DATA: begin
        if (w_hs_s) begin
          beat_d   = beat_q + 8'd1;
          wstate_d = (beat_q == len_q) ? W_RESP : W_DATA;
        end else begin
          wstate_d = W_DATA;
        end
      end
      W_RESP: begin
        if (b_valid_i) begin
          wstate_d    = W_IDLE;
          addr_d      = addr_q + burst_bytes(len_q);
          bresp_err_d = bresp_err_q | (b_resp_i != AXI_RESP_OKAY);
        end else begin
          wstate_d = W_RESP;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    if (arm_accept_s) begin
      addr_d      = base_addr_i;
      bresp_err_d = 1'b0;
    end else begin
      addr_d = addr_d;
    end
  end

  always_comb begin
    occ_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, push_q} + {{CNT_W{1'b0}}, push_d};
    rx_ready_d = ((fstate_d == F_ARMED) || (fstate_d == F_RECV)) && !fifo_full_s && (occ_s < DEPTH_C);
    status_d    = status_q;
    frame_len_d = frame_len_q;
    if (arm_accept_s) begin
      status_d    = 3'd0;
      frame_len_d = {LEN_W{1'b0}};
    end else if (fstate_d == F_DONE) begin
      status_d[STAT_RX_ERR]    = rx_err_q;
      status_d[STAT_OVERFLOW]  = overflow_q;
      status_d[STAT_BRESP_ERR] = bresp_err_d;
      frame_len_d              = byte_cnt_q;
    end else begin
      status_d = status_q;
    end
  end

  always_comb begin
    aw_valid_o  = (wstate_q == W_AW);
    aw_addr_o   = addr_q;
    aw_len_o    = len_q;
    w_valid_o   = (wstate_q == W_DATA);
    w_data_o    = w_valid_o ? fifo_rdata_s[31:0] : 32'd0;
    w_strb_o    = w_valid_o ? fifo_rdata_s[35:32] : 4'd0;
    w_last_o    = w_valid_o && (beat_q == len_q);
    b_ready_o   = (wstate_q == W_RESP);
    rx_ready_o  = rx_ready_q;
    busy_o      = busy_q;
    done_o      = done_q;
    frame_len_o = frame_len_q;
    status_o    = status_q;
  end

endmodule

// File: tb/tb_eth_rx_axi_writer.sv
// Self-checking bench: expected words are queued as bytes are accepted and
// compared against each AXI write beat; frame length/status checked at done.
module tb_eth_rx_axi_writer;

  localparam int BL = 4;
  localparam int FD = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm_i = 1'b0;
  logic [31:0]   base_addr_i = 32'd0;
  logic [LW-1:0] buf_len_i = '0;
  logic [7:0]    rx_data_i = 8'd0;
  logic          rx_valid_i = 1'b0, rx_last_i = 1'b0, rx_err_i = 1'b0;
  logic          rx_ready_o;
  logic          aw_valid_o, aw_ready_i = 1'b1;
  logic [31:0]   aw_addr_o;
  logic [7:0]    aw_len_o;
  logic          w_valid_o, w_ready_i = 1'b1;
  logic [31:0]   w_data_o;
  logic [3:0]    w_strb_o;
  logic          w_last_o;
  logic          b_valid_i = 1'b0, b_ready_o;
  logic [1:0]    b_resp_i = 2'b00;
  logic          busy_o, done_o;
  logic [LW-1:0] frame_len_o;
  logic [2:0]    status_o;

  eth_rx_axi_writer #(.BURST_LEN(BL), .FIFO_DEPTH(FD), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .arm_i(arm_i), .base_addr_i(base_addr_i), .buf_len_i(buf_len_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_last_i(rx_last_i), .rx_err_i(rx_err_i),
    .rx_ready_o(rx_ready_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o), .b_valid_i(b_valid_i),
    .b_ready_o(b_ready_o), .b_resp_i(b_resp_i), .busy_o(busy_o), .done_o(done_o),
    .frame_len_o(frame_len_o), .status_o(status_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
    return m;
  endfunction

  // Slave-side state
  logic        stall_w = 1'b0;
  logic        want_full = 1'b0;
  int          err_burst = -1;
  int          bursts_total = 0;
  int          b_pend = 0;
  int          beat_idx = 0;
  logic [31:0] aw_addr_l = 32'd0;
  logic [7:0]  aw_len_l = 8'd0;

  // AXI slave model: drive ready/response at negedge, score the beats that handshake next edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      b_pend    = 0;
      b_valid_i = 1'b0;
      beat_idx  = 0;
    end else begin
      exp_t e;
      w_ready_i = !stall_w;
      b_valid_i = (b_pend != 0);
      b_resp_i  = (bursts_total == err_burst) ? 2'b10 : 2'b00;
      if (aw_valid_o && aw_ready_i) begin
        aw_addr_l = aw_addr_o;
        aw_len_l  = aw_len_o;
        beat_idx  = 0;
        if (want_full) chk_eq("aw_len", aw_len_o, BL - 1);
      end
      if (w_valid_o && w_ready_i) begin
        if (sb.size() == 0) begin
          chk_eq("w_extra_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          chk_eq("w_addr", aw_addr_l + 32'(4 * beat_idx), e.addr);
          chk_eq("w_strb", w_strb_o, e.strb);
          chk_eq("w_data", w_data_o & strb_mask(e.strb), e.data & strb_mask(e.strb));
          chk_eq("w_last", w_last_o, (8'(beat_idx) == aw_len_l));
        end
        if (8'(beat_idx) == aw_len_l) b_pend = 1;
        beat_idx++;
      end
      if (b_valid_i && b_ready_o) begin
        b_pend = 0;
        bursts_total++;
      end
    end
  end

  // Reference packing state, owned by the main sequence
  logic [31:0]   cur_base;
  int            cur_len;
  logic [31:0]   exp_addr;
  logic [31:0]   m_data;
  logic [3:0]    m_strb;
  logic          rdy_low_seen = 1'b0;

  task automatic arm(input logic [31:0] base, input int len);
    @(negedge clk);
    arm_i = 1'b1; base_addr_i = base; buf_len_i = LW'(len);
    cur_base = base; cur_len = len; exp_addr = base; m_data = 32'd0; m_strb = 4'd0;
    @(negedge clk);
    arm_i = 1'b0;
    chk_eq("busy_after_arm", busy_o, 1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic err, input int k);
    bit ok = 0;
    bit acc;
    rx_data_i = d; rx_valid_i = 1'b1; rx_last_i = last; rx_err_i = err;
    for (int c = 0; c < 2000; c++) begin
      acc = rx_ready_o;
      if (!acc && stall_w) rdy_low_seen = 1'b1;
      @(negedge clk);
      arm_i = 1'b0;
      if (acc) begin ok = 1; break; end
    end
    if (!ok) chk_eq("rx_accept_timeout", 0, 1);
    if (k < cur_len) begin
      m_data[8*(k%4) +: 8] = d;
      m_strb[k%4] = 1'b1;
    end
    if ((k < cur_len && k % 4 == 3) || (last && m_strb != 4'd0)) begin
      sb.push_back('{addr: exp_addr, data: m_data, strb: m_strb});
      exp_addr = exp_addr + 32'd4;
      m_data = 32'd0; m_strb = 4'd0;
    end
  endtask

  task automatic send_frame(input int n, input int arm_at, input logic err_last, input logic with_last);
    for (int k = 0; k < n; k++) begin
      if (k == arm_at) begin
        arm_i = 1'b1; base_addr_i = 32'h0020_0000; buf_len_i = LW'(8);
      end
      send_byte(8'($urandom_range(0, 255)), with_last && (k == n - 1),
                err_last && (k == n - 1), k);
    end
    rx_valid_i = 1'b0; rx_last_i = 1'b0; rx_err_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_len, input logic [2:0] exp_st);
    bit seen = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done_o) begin seen = 1; break; end
      @(negedge clk);
    end
    chk_eq({tag, "_done_seen"}, seen, 1);
    chk_eq({tag, "_frame_len"}, frame_len_o, exp_len);
    chk_eq({tag, "_status"}, status_o, exp_st);
    chk_eq({tag, "_sb_empty"}, sb.size(), 0);
    chk_eq({tag, "_busy_at_done"}, busy_o, 0);
    @(negedge clk);
    chk_eq({tag, "_done_pulse"}, done_o, 0);
    chk_eq({tag, "_len_held"}, frame_len_o, exp_len);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_ctl", {rx_ready_o, aw_valid_o, w_valid_o, w_last_o, b_ready_o, busy_o, done_o, status_o}, 0);
    chk_eq("rst_len", frame_len_o, 0);
    chk_eq("rst_addr", {aw_addr_o, w_data_o}, 0);
    rst = 1'b0;

    // 64-byte frame: four full bursts
    arm(32'h0010_0000, 1536);
    want_full = 1'b1; b0 = bursts_total;
    send_frame(64, -1, 1'b0, 1'b1);
    wait_done("f64", 64, 3'b000);
    chk_eq("f64_bursts", bursts_total - b0, 4);

    // 61-byte frame: final word strobe 4'b0001
    arm(32'h0010_0000, 1536);
    b0 = bursts_total;
    send_frame(61, -1, 1'b0, 1'b1);
    wait_done("f61", 61, 3'b000);
    chk_eq("f61_bursts", bursts_total - b0, 4);
    want_full = 1'b0;

    // Overflow: 100 bytes into a 64-byte buffer
    arm(32'h0010_1000, 64);
    send_frame(100, -1, 1'b0, 1'b1);
    wait_done("ovf", 100, 3'b010);

    // Write-data stall long enough to fill the FIFO
    arm(32'h0010_2000, 1536);
    rdy_low_seen = 1'b0;
    fork
      send_frame(200, -1, 1'b0, 1'b1);
      begin
        repeat (30) @(negedge clk);
        stall_w = 1'b1;
        repeat (40) @(negedge clk);
        stall_w = 1'b0;
      end
    join
    wait_done("stall", 200, 3'b000);
    chk_eq("stall_rdy_drop", rdy_low_seen, 1);

    // SLVERR on the second burst plus MAC error on the last byte
    arm(32'h0010_3000, 1536);
    err_burst = bursts_total + 1;
    send_frame(40, -1, 1'b1, 1'b1);
    wait_done("err", 40, 3'b101);
    err_burst = -1;

    // Re-arm attempt mid-frame must be ignored
    arm(32'h0010_4000, 1536);
    send_frame(48, 10, 1'b0, 1'b1);
    wait_done("rearm", 48, 3'b000);

    // Reset while a burst is stuck in the data phase
    arm(32'h0010_5000, 1536);
    stall_w = 1'b1;
    send_frame(16, -1, 1'b0, 1'b0);
    for (int c = 0; c < 200; c++) begin
      if (w_valid_o) break;
      @(negedge clk);
    end
    chk_eq("rst_mid_wvalid", w_valid_o, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_eq("rst_mid_ctl", {rx_ready_o, aw_valid_o, w_valid_o, w_last_o, b_ready_o, busy_o, done_o, status_o}, 0);
    chk_eq("rst_mid_data", {aw_addr_o, w_data_o}, 0);
    rst = 1'b0; stall_w = 1'b0;
    @(negedge clk);

    arm(32'h0010_6000, 1536);
    send_frame(64, -1, 1'b0, 1'b1);
    wait_done("post_rst", 64, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
